vc_plane_scheduler: RTL and testbench



---
 rtl/noc_vc_pkg.sv | 19 +
 rtl/vc_rr_picker.sv | 35 +++
 rtl/vc_plane_scheduler.sv | 128 ++++++++++++
 tb/tb_vc_plane_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_pkg.sv
// Shared types and width helpers for the VC plane scheduler and VC allocators.
package noc_vc_pkg;

    typedef enum logic {
        IDLE,
        SERVE
    } sched_state_t;

    // Selector carries one spare bit so the index type matches other VC-indexed buses.
    function automatic int unsigned sel_width(input int unsigned vc);
        return vc + 1;
    endfunction

    // Enough bits to hold 0..limit inclusive, so saturating counters never wrap.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/vc_rr_picker.sv
// Combinational round-robin picker: first pending index after cur_i, wrapping back to cur_i.
module vc_rr_picker
    import noc_vc_pkg::*;
#(
    parameter int unsigned VC = 4
) (
    input  logic [VC-1:0] pending_i,
    input  logic [VC:0]   cur_i,
    output logic [VC:0]   next_o,
    output logic          any_o
);

    localparam int unsigned SelW = sel_width(VC);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        next_o = cur_i;
        // Scan farthest-first so the nearest pending plane is the last (winning) write.
        for (int unsigned k = VC; k >= 1; k--) begin
            idx = int'(cur_i) + k;
            if (idx >= VC) begin
                idx = idx - VC;
            end
            for (int unsigned v = 0; v < VC; v++) begin
                if (v == idx && pending_i[v]) begin
                    next_o = SelW'(v);
                end
            end
        end
    end

    assign any_o = |pending_i;

endmodule

// File: rtl/vc_plane_scheduler.sv
// Round-robin time-slicing of the crossbar among VC planes with quantum and stall-based release.
module vc_plane_scheduler
    import noc_vc_pkg::*;
#(
    parameter int unsigned VC          = 4,
    parameter int unsigned INPUTS      = 4,
    parameter int unsigned QUANTUM     = 4,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VC-1:0][INPUTS-1:0]    valid_out_portVC,
    input  logic [VC-1:0][INPUTS-1:0]    PortReservedVC,
    input  logic [INPUTS-1:0]            valid_in_switch,
    input  logic [INPUTS-1:0]            ready_in_switch,
    output logic [VC:0]                  VCPlaneSelector,
    output logic                         plane_switch,
    output logic [VC-1:0]                vc_pending
);

    localparam int unsigned SelW = sel_width(VC);
    localparam int unsigned QW   = cnt_width(QUANTUM);
    localparam int unsigned SW   = cnt_width(STALL_LIMIT);

    sched_state_t    state_q, state_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [QW-1:0]   qcnt_q, qcnt_d, qcnt_nxt;
    logic [SW-1:0]   scnt_q, scnt_d, scnt_nxt;
    logic            switch_q, switch_d;

    logic            fire, want, stall, sel_pend, release_now, any_pend;
    logic [SelW-1:0] next_rr;

    always_comb begin
        for (int unsigned v = 0; v < VC; v++) begin
            vc_pending[v] = (|valid_out_portVC[v]) | (|PortReservedVC[v]);
        end
    end

    always_comb begin
        sel_pend = 1'b0;
        for (int unsigned v = 0; v < VC; v++) begin
            if (sel_q == SelW'(v)) begin
                sel_pend = vc_pending[v];
            end
        end
    end

    assign fire  = |(valid_in_switch & ready_in_switch);
    assign want  = |valid_in_switch;
    assign stall = want & ~fire;

    always_comb begin
        qcnt_nxt = qcnt_q;
        if (fire && qcnt_q != QW'(QUANTUM)) begin
            qcnt_nxt = qcnt_q + QW'(1);
        end
        scnt_nxt = '0;
        if (stall) begin
            scnt_nxt = (scnt_q != SW'(STALL_LIMIT)) ? scnt_q + SW'(1) : scnt_q;
        end
    end

    // Quantum and stall hits collapse into one release, so rotation advances once.
    assign release_now = ~sel_pend | (qcnt_nxt == QW'(QUANTUM)) | (scnt_nxt == SW'(STALL_LIMIT));

    vc_rr_picker #(
        .VC (VC)
    ) u_picker (
        .pending_i (vc_pending),
        .cur_i     (sel_q),
        .next_o    (next_rr),
        .any_o     (any_pend)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        qcnt_d  = qcnt_q;
        scnt_d  = scnt_q;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    sel_d   = next_rr;
                    state_d = SERVE;
                    qcnt_d  = '0;
                    scnt_d  = '0;
                end
            end
            SERVE: begin
                if (release_now) begin
                    qcnt_d = '0;
                    scnt_d = '0;
                    if (any_pend) begin
                        sel_d = next_rr;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    qcnt_d = qcnt_nxt;
                    scnt_d = scnt_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
        switch_d = (sel_d != sel_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            qcnt_q   <= '0;
            scnt_q   <= '0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            qcnt_q   <= qcnt_d;
            scnt_q   <= scnt_d;
            switch_q <= switch_d;
        end
    end

    assign VCPlaneSelector = sel_q;
    assign plane_switch    = switch_q;

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Directed bench for vc_plane_scheduler with a behavioural mux feeding valid_in_switch back.
module tb_vc_plane_scheduler;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0][3:0]  vo;
    logic [3:0][3:0]  pr;
    logic [3:0]       vis;
    logic [3:0]       rdy;
    logic [4:0]       sel;
    logic             sw;
    logic [3:0]       pend;
    logic [1:0]       sel_idx;

    int n_cmp = 0;
    int n_bad = 0;

    int e2_sel [13] = '{2, 2, 2, 2, 0, 0, 0, 0, 2, 2, 2, 2, 0};
    int e2_sw  [13] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    always #5 clk = ~clk;

    // Downstream mux model: returns the selected plane's valids.
    assign sel_idx = sel[1:0];
    assign vis     = vo[sel_idx];

    vc_plane_scheduler #(
        .VC          (4),
        .INPUTS      (4),
        .QUANTUM     (4),
        .STALL_LIMIT (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_out_portVC (vo),
        .PortReservedVC   (pr),
        .valid_in_switch  (vis),
        .ready_in_switch  (rdy),
        .VCPlaneSelector  (sel),
        .plane_switch     (sw),
        .vc_pending       (pend)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check outputs settle at once, release after one edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_sel"}, 32'(sel), 32'd0);
        check_eq({tag, "_rst_sw"}, 32'(sw), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        vo  = '1;
        pr  = '0;
        rdy = '0;

        // 1: reset with everything valid, first grant goes to plane 1
        #1;
        check_eq("s1_rst_sel", 32'(sel), 32'd0);
        check_eq("s1_rst_sw", 32'(sw), 32'd0);
        tick();
        check_eq("s1_rst_edge_sel", 32'(sel), 32'd0);
        check_eq("s1_rst_edge_sw", 32'(sw), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("s1_first_sel", 32'(sel), 32'd1);
        check_eq("s1_first_sw", 32'(sw), 32'd1);
        tick();
        check_eq("s1_hold_sel", 32'(sel), 32'd1);
        check_eq("s1_hold_sw", 32'(sw), 32'd0);

        // 2: planes 0 and 2 pending, ready all ones, 4-cycle dwell
        vo    = '0;
        vo[0] = 4'b1111;
        vo[2] = 4'b1111;
        rdy   = 4'b1111;
        do_reset("s2");
        check_eq("s2_pending", 32'(pend), 32'h5);
        for (int i = 0; i < 13; i++) begin
            tick();
            check_eq($sformatf("s2_sel_%0d", i), 32'(sel), 32'(e2_sel[i]));
            check_eq($sformatf("s2_sw_%0d", i), 32'(sw), 32'(e2_sw[i]));
        end

        // 3: lone plane 3 with continuous fires never toggles
        vo    = '0;
        vo[3] = 4'b0110;
        do_reset("s3");
        tick();
        check_eq("s3_first_sel", 32'(sel), 32'd3);
        check_eq("s3_first_sw", 32'(sw), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq($sformatf("s3_sel_%0d", i), 32'(sel), 32'd3);
            check_eq($sformatf("s3_sw_%0d", i), 32'(sw), 32'd0);
        end

        // 4: plane 1 stalls (valid 0001, ready 0), plane 2 waiting
        vo    = '0;
        vo[1] = 4'b0001;
        vo[2] = 4'b1111;
        rdy   = 4'b0000;
        do_reset("s4");
        tick();
        check_eq("s4_first_sel", 32'(sel), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq($sformatf("s4_stall_sel_%0d", i), 32'(sel), 32'd1);
        end
        tick();
        check_eq("s4_rotate_sel", 32'(sel), 32'd2);
        check_eq("s4_rotate_sw", 32'(sw), 32'd1);

        // 5a: lone plane 0 reselected without a pulse, then drops; plane 3 reserved only
        vo    = '0;
        vo[0] = 4'b0001;
        do_reset("s5a");
        tick();
        check_eq("s5a_self_sel", 32'(sel), 32'd0);
        check_eq("s5a_self_sw", 32'(sw), 32'd0);
        tick();
        vo    = '0;
        pr[3] = 4'b0100;
        #1;
        check_eq("s5a_pending", 32'(pend), 32'h8);
        tick();
        check_eq("s5a_drop_sel", 32'(sel), 32'd3);
        check_eq("s5a_drop_sw", 32'(sw), 32'd1);
        tick();
        check_eq("s5a_reserved_hold", 32'(sel), 32'd3);

        // 5b: plane 0 drops with nothing else pending, selector holds
        pr    = '0;
        vo    = '0;
        vo[0] = 4'b0001;
        do_reset("s5b");
        tick();
        tick();
        vo = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("s5b_idle_sel_%0d", i), 32'(sel), 32'd0);
            check_eq($sformatf("s5b_idle_sw_%0d", i), 32'(sw), 32'd0);
        end
        vo[1] = 4'b0010;
        tick();
        check_eq("s5b_wake_sel", 32'(sel), 32'd1);

        // 6: async reset mid-SERVE on plane 2 with qcnt=3
        vo    = '0;
        vo[0] = 4'b1111;
        vo[2] = 4'b1111;
        rdy   = 4'b1111;
        do_reset("s6pre");
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_eq("s6_before_sel", 32'(sel), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check_eq("s6_async_sel", 32'(sel), 32'd0);
        check_eq("s6_async_sw", 32'(sw), 32'd0);
        vo = '1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("s6_restart_sel", 32'(sel), 32'd1);
        check_eq("s6_restart_sw", 32'(sw), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
